// File: rtl/pattern_tx.sv
// pattern_tx: plays a programmable table of NSEG (level, length) segments as
// a single-bit waveform on d_out.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start / stop / loop         begin playback (IDLE), abort (RUN), wrap at end
//   cfg_we/cfg_addr/cfg_level/cfg_len   table write port, honoured in IDLE only
//   d_out                       waveform (registered)
//   busy                        high while playing
//   done                        one-cycle pulse when playback ends or is stopped
//   seg_idx                     segment currently driven on d_out
//
// FSM states:
//   state | meaning
//   IDLE  | outputs parked low, table writable, waiting for start
//   RUN   | driving level[seg_idx] until the duration counter reaches 0
module pattern_tx #(
  parameter int NSEG  = 6,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic                     cfg_we,
  input  logic [$clog2(NSEG)-1:0]  cfg_addr,
  input  logic                     cfg_level,
  input  logic [CNT_W-1:0]         cfg_len,
  output logic                     d_out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NSEG)-1:0]  seg_idx
);

  localparam int AW = $clog2(NSEG);
  localparam logic [AW-1:0] LAST_SEG = AW'(NSEG - 1);
  localparam logic [AW:0]   NSEG_EXT = (AW + 1)'(NSEG);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             level_q [NSEG];
  logic [CNT_W-1:0] len_q   [NSEG];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    seg_q, seg_d, seg_inc;
  logic             d_out_q, d_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tc, last_seg, cfg_hit;

  // Counter load value: a segment of length 0 still occupies one cycle.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  assign tc       = (cnt_q == '0);
  assign last_seg = (seg_q == LAST_SEG);
  assign seg_inc  = seg_q + AW'(1);
  assign cfg_hit  = cfg_we && (state_q == IDLE) && ({1'b0, cfg_addr} < NSEG_EXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) begin
        level_q[i] <= 1'b0;
        len_q[i]   <= CNT_W'(1);
      end
    end else if (cfg_hit) begin
      level_q[cfg_addr] <= cfg_level;
      len_q[cfg_addr]   <= cfg_len;
    end
  end

  // State register, together with the registered outputs and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seg_q   <= '0;
      d_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      d_out_q <= d_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (stop)                            state_d = IDLE;
        else if (tc && last_seg && !loop)    state_d = IDLE;
      end
    endcase
  end

  // Next values for the registered outputs; stop outranks advance and wrap.
  always_comb begin
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    d_out_d = d_out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        seg_d   = '0;
        d_out_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          cnt_d   = load_val(len_q[0]);
          d_out_d = level_q[0];
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          cnt_d   = '0;
          seg_d   = '0;
          d_out_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (tc) begin
          if (!last_seg) begin
            seg_d   = seg_inc;
            cnt_d   = load_val(len_q[seg_inc]);
            d_out_d = level_q[seg_inc];
          end else if (loop) begin
            seg_d   = '0;
            cnt_d   = load_val(len_q[0]);
            d_out_d = level_q[0];
          end else begin
            cnt_d   = '0;
            seg_d   = '0;
            d_out_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  assign d_out   = d_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign seg_idx = seg_q;

endmodule
